fetch_unit: RTL and testbench

//   Instruction-fetch stage directly upstream of the mips core. Issues sequential word

---
 rtl/mips_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 65 ++++++
 rtl/fetch_unit.sv | 123 ++++++++++++
 tb/tb_fetch_unit.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types for the mips front end.
// Fetch FSM states and the prefetch queue entry layout.
package mips_pkg;

    localparam int INSTR_W = 32;

    typedef enum logic [1:0] {
        FS_IDLE,
        FS_RUN,
        FS_FLUSH
    } fetch_state_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [INSTR_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO with flush and a registered-storage head.
// Flush has priority over push and pop in the same cycle.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1))
            return '0;
        return p + PW'(1);
    endfunction

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign count   = cnt;
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push)
                wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)
                rd_ptr <= next_ptr(rd_ptr);
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential word prefetch into a small queue,
// valid/ready delivery to the core, redirect flush with response drop.
module fetch_unit
    import mips_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    input  logic        instr_ready_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i
);

    localparam int CW   = $clog2(DEPTH + 1);
    localparam int CAPW = CW + 1;
    localparam logic [CAPW-1:0] CAP = CAPW'(DEPTH);

    fetch_state_e state;
    fetch_state_e state_nx;

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [31:0]   redir_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] out_nx;
    logic [CW-1:0] count;
    logic [CAPW-1:0] inflight;
    logic          fifo_full;
    logic          fifo_empty;
    logic          req;
    logic          gnt_acc;
    logic          push;
    logic          pop;
    fetch_entry_t  wr_entry;
    fetch_entry_t  head;

    assign redir_pc = redirect_pc_i & 32'hFFFF_FFFC;
    assign inflight = {1'b0, count} + {1'b0, outstanding};
    assign gnt_acc  = req && imem_gnt_i;
    assign out_nx   = outstanding + CW'(gnt_acc) - CW'(imem_rvalid_i);
    assign push     = imem_rvalid_i && (state == FS_RUN);
    assign pop      = instr_valid_o && instr_ready_i;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= FS_IDLE;
        else
            state <= state_nx;
    end

    // Leave FLUSH only once every discarded response has come back
    always_comb begin
        state_nx = state;
        unique case (state)
            FS_IDLE:  state_nx = FS_RUN;
            FS_RUN:   if (redirect_i && out_nx != '0)
                          state_nx = FS_FLUSH;
            FS_FLUSH: if (!redirect_i && out_nx == '0)
                          state_nx = FS_RUN;
            default:  state_nx = FS_IDLE;
        endcase
    end

    always_comb begin
        req = (state == FS_RUN) && !redirect_i
            && !fifo_full && (inflight < CAP);
        imem_req_o  = req;
        imem_addr_o = req ? fetch_pc : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
        end else begin
            outstanding <= out_nx;
            if (redirect_i) begin
                fetch_pc <= redir_pc;
                resp_pc  <= redir_pc;
            end else begin
                if (gnt_acc)
                    fetch_pc <= fetch_pc + 32'd4;
                if (push)
                    resp_pc <= resp_pc + 32'd4;
            end
        end
    end

    assign wr_entry.instr = imem_rdata_i;
    assign wr_entry.pc    = resp_pc;

    fetch_fifo #(
        .WIDTH (2 * INSTR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect_i),
        .din   (wr_entry),
        .dout  (head),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign instr_valid_o = !fifo_empty;
    assign instr_o       = head.instr;
    assign pc_o          = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a latency-configurable memory model.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        instr_ready_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;

    fetch_unit #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .instr_ready_i (instr_ready_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    typedef struct {
        logic        ready;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
    } vec_t;

    pend_t       pend[$];
    vec_t        tab[11];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          lat = 1;
    int          pops;
    logic [31:0] exp_pc;

    function automatic logic [31:0] fdat(input logic [31:0] a);
        return (a * 32'd3) ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive_mem();
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = fdat(pend[0].addr);
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = '0;
        end
    endtask

    // One cycle: scoreboard the pop, record grant/response, advance.
    task automatic step();
        logic        acc;
        logic        rv;
        logic [31:0] aa;
        if (instr_valid_o && instr_ready_i && !redirect_i) begin
            chk("pop_pc", pc_o, exp_pc);
            chk("pop_instr", instr_o, fdat(exp_pc));
            exp_pc += 32'd4;
        end
        acc = imem_req_o && imem_gnt_i;
        aa  = imem_addr_o;
        rv  = imem_rvalid_i;
        @(posedge clk);
        cyc++;
        if (rv && pend.size() > 0)
            pend.delete(0);
        if (acc)
            pend.push_back('{addr: aa, due: cyc + lat - 1});
        @(negedge clk);
        drive_mem();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        chk("rst_req", {31'b0, imem_req_o}, 32'd0);
        chk("rst_addr", imem_addr_o, 32'd0);
        chk("rst_valid", {31'b0, instr_valid_o}, 32'd0);
        chk("rst_instr", instr_o, 32'd0);
        chk("rst_pc", pc_o, 32'd0);
        pend.delete();
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        exp_pc        = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
    endtask

    task automatic wait_valid(input int budget, input string name,
                              input logic [31:0] want_pc);
        int n;
        n = 0;
        while (!instr_valid_o && n < budget) begin
            step();
            n++;
        end
        if (!instr_valid_o) begin
            total++;
            bad++;
            $display("FAIL %s: no instr_valid_o within %0d cycles", name, budget);
        end else begin
            chk(name, pc_o, want_pc);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset         = 1'b0;
        imem_gnt_i    = 1'b1;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
        instr_ready_i = 1'b1;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        exp_pc        = '0;

        tab[0]  = '{1'b1, 1'b0, 32'h00, 1'b0, 32'h0};
        tab[1]  = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h0};
        tab[2]  = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h0};
        tab[3]  = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h0};
        tab[4]  = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h4};
        tab[5]  = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h8};
        tab[6]  = '{1'b0, 1'b1, 32'h14, 1'b1, 32'hC};
        tab[7]  = '{1'b0, 1'b1, 32'h18, 1'b1, 32'hC};
        tab[8]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'hC};
        tab[9]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'hC};
        tab[10] = '{1'b0, 1'b0, 32'h00, 1'b1, 32'hC};

        @(negedge clk);
        #1;

        // streaming at L=1, then back-pressure until the queue fills
        lat = 1;
        do_reset();
        for (int i = 0; i < 11; i++) begin
            instr_ready_i = tab[i].ready;
            #1;
            chk($sformatf("v%0d_req", i), {31'b0, imem_req_o},
                {31'b0, tab[i].req});
            chk($sformatf("v%0d_addr", i), imem_addr_o, tab[i].addr);
            chk($sformatf("v%0d_valid", i), {31'b0, instr_valid_o},
                {31'b0, tab[i].valid});
            chk($sformatf("v%0d_pc", i), pc_o, tab[i].pc);
            chk($sformatf("v%0d_instr", i), instr_o,
                tab[i].valid ? fdat(tab[i].pc) : 32'h0);
            step();
        end

        instr_ready_i = 1'b1;
        #1;
        pops = 0;
        for (int k = 0; k < 12; k++) begin
            if (instr_valid_o)
                pops++;
            step();
        end
        chk("resume_pops", pops, 32'd12);
        chk("resume_next_pc", exp_pc, 32'h3C);

        // redirect with two responses in flight at L=3
        lat = 3;
        do_reset();
        repeat (3) step();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h100;
        exp_pc        = 32'h100;
        #1;
        chk("t3_req_redir", {31'b0, imem_req_o}, 32'd0);
        step();
        redirect_i = 1'b0;
        #1;
        chk("t3_flush_req0", {31'b0, imem_req_o}, 32'd0);
        chk("t3_flush_valid0", {31'b0, instr_valid_o}, 32'd0);
        step();
        chk("t3_flush_req1", {31'b0, imem_req_o}, 32'd0);
        step();
        chk("t3_run_req", {31'b0, imem_req_o}, 32'd1);
        chk("t3_run_addr", imem_addr_o, 32'h100);
        wait_valid(20, "t3_first_pc", 32'h100);
        repeat (4) step();

        // redirect coinciding with the last response and a pop
        lat = 1;
        do_reset();
        repeat (3) step();
        chk("t4_pre_valid", {31'b0, instr_valid_o}, 32'd1);
        chk("t4_pre_rvalid_pc", pc_o, 32'h0);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h200;
        exp_pc        = 32'h200;
        #1;
        step();
        redirect_i = 1'b0;
        #1;
        chk("t4_empty", {31'b0, instr_valid_o}, 32'd0);
        chk("t4_req", {31'b0, imem_req_o}, 32'd1);
        chk("t4_addr", imem_addr_o, 32'h200);
        step();
        chk("t4_addr_next", imem_addr_o, 32'h204);
        step();
        chk("t4_valid", {31'b0, instr_valid_o}, 32'd1);
        chk("t4_pc", pc_o, 32'h200);
        repeat (3) step();

        // grant withheld: request holds its address, then realigned redirect
        imem_gnt_i = 1'b0;
        do_reset();
        step();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("t5_req%0d", k), {31'b0, imem_req_o}, 32'd1);
            chk($sformatf("t5_addr%0d", k), imem_addr_o, 32'h0);
            step();
        end
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h203;
        exp_pc        = 32'h200;
        #1;
        chk("t5_req_redir", {31'b0, imem_req_o}, 32'd0);
        step();
        redirect_i = 1'b0;
        imem_gnt_i = 1'b1;
        #1;
        chk("t5_req_after", {31'b0, imem_req_o}, 32'd1);
        chk("t5_addr_after", imem_addr_o, 32'h200);
        wait_valid(10, "t5_first_pc", 32'h200);
        repeat (3) step();

        // reset asserted while flushing two outstanding fetches
        lat = 3;
        do_reset();
        repeat (3) step();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h100;
        exp_pc        = 32'h100;
        #1;
        step();
        redirect_i = 1'b0;
        #1;
        chk("t6_in_flush", {31'b0, imem_req_o}, 32'd0);
        do_reset();
        step();
        chk("t6_restart_req", {31'b0, imem_req_o}, 32'd1);
        chk("t6_restart_addr", imem_addr_o, 32'h0);
        wait_valid(20, "t6_first_pc", 32'h0);
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
